display_source: RTL and testbench
=================================

Name: display_source

Overview:
- Front-panel source selector directly upstream of the 4-digit octal display scanner.
- Debounces a pushbutton and cycles through four 12-bit CPU registers: PC, AC, MA, MB.
- Registers the selected word onto the scanner's 12-bit value input. Drives the 4 decimal-point enables so the selected register is shown one-hot.
- Supports a freeze switch that holds the displayed value while the CPU runs.

Parameters:
- DEBOUNCE_W, 16: debounce counter width. A level change is accepted after 2^DEBOUNCE_W consecutive differing synchronized samples.
- AUTO_W, 24: auto-cycle timer width. Used only with DISPLAY_AUTOCYCLE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_raw  in  1  asynchronous pushbutton, high = pressed
- freeze  in  1  level; 1 = hold the displayed value
- pc  in  12  program counter
- ac  in  12  accumulator
- ma  in  12  memory address
- mb  in  12  memory buffer
- value  out  12  word to the display scanner's pc input
- dots  out  4  decimal-point enables to the scanner's dots input
- sel  out  2  current selection: 0=PC, 1=AC, 2=MA, 3=MB

Behaviour:
- Reset: everything is synchronous on clk, with reset dominant over all other activity. On reset, each of the following is cleared and takes effect on the next edge:
  - sync flops, stable, cnt
  - sel=0
  - value=12'o0000
  - dots=4'b0001
  - auto timer (feature builds only)
- Reset mid-debounce discards any partial count. A button held through reset release is seen as a new press after full debounce, because stable=0.
- Synchronizer: two flops, s1 <= btn_raw and s2 <= s1. s2 follows btn_raw after 2 edges.
- Debounce:
  - If s2 == stable: cnt <= 0.
  - Otherwise, if cnt == all-ones: stable <= s2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any single-cycle return of s2 to stable restarts the count.
- Press event: the cycle in which stable goes 0->1 (cnt all-ones, s2=1, stable=0).
  - On that edge, sel <= sel+1, wrapping modulo 4 (3 -> 0).
  - The release (1->0 acceptance) causes no action.
- dots: registered, dots <= 4'b0001 << sel_next. The update is coincident with sel, i.e. dots always equals the one-hot of sel.
- value: registered mux of {pc, ac, ma, mb}[sel], one cycle latency from sel or a source change.
  - freeze=0: value loads every cycle.
  - freeze=1: value holds.
  - Exception: on the cycle after sel changes, value loads once even while frozen, so the new register is shown as a snapshot.
- Simultaneous press and freeze rising edge: sel still advances, and the new selection is snapshotted once.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DISPLAY_AUTOCYCLE_EN.
- Defined:
  - An AUTO_W-bit timer increments every cycle.
  - When the timer is all-ones and no press event occurs that cycle, sel advances exactly as for a press, and the timer wraps to 0.
  - A press event clears the timer to 0.
  - freeze=1 holds the timer, so no auto-advance occurs while frozen.
- Undefined: no timer logic is present; sel changes only on press events.

Test Plan:
- Reset and pass-through: DEBOUNCE_W=4. Assert reset 3 cycles, with pc=12'o1234 and freeze=0. Required:
  - value=0, sel=0, dots=0001 during reset.
  - value=1234 on the 1st edge after reset drops.
  - When pc changes to 12'o7777, value=7777 one cycle later.
- Clean press: DEBOUNCE_W=4, btn_raw rises before edge 1 and stays high. Required:
  - sel=1 and dots=0010 after edge 18.
  - value=ac after edge 19.
  - Releasing the button and waiting 20 cycles leaves sel=1.
- Bounce rejection: btn_raw high 10 cycles, low 1 cycle, high 10 cycles -> no sel change. Holding high 16 more cycles then advances sel by exactly 1.
- Wrap: 4 clean presses from sel=0 -> sel sequence 1, 2, 3, 0 and dots sequence 0010, 0100, 1000, 0001.
- Freeze snapshot: freeze=1 with value showing pc=12'o0100, then pc changes to 12'o0200. Required:
  - value stays 0100.
  - A press with ma=12'o0555 gives value=0555 one cycle after sel=2, then holds even when ma changes.
  - freeze=0 resumes tracking.
- Auto-cycle (DISPLAY_AUTOCYCLE_EN, AUTO_W=4, freeze=0): sel advances every 16 cycles. A press at timer=8 advances sel and delays the next auto-advance to 16 cycles later. With freeze=1, no advances occur over 40 cycles.

Source files
------------

// File: rtl/display_source.sv
// rtl/display_source.sv - front-panel register selector feeding the octal display scanner
//
// Picks one of four 12-bit CPU registers (PC, AC, MA, MB) for the 4-digit
// display. A debounced pushbutton steps the selection round-robin. The
// selection is also shown as a one-hot decimal-point pattern.
//
// Ports:
//   clk      in   1  system clock
//   reset    in   1  synchronous, active-high reset
//   btn_raw  in   1  asynchronous pushbutton, high = pressed
//   freeze   in   1  1 = hold the displayed value (snapshot on selection change)
//   pc       in  12  program counter
//   ac       in  12  accumulator
//   ma       in  12  memory address
//   mb       in  12  memory buffer
//   value    out 12  registered word to the scanner's value input
//   dots     out  4  registered decimal-point enables, one-hot of sel
//   sel      out  2  current selection: 0=PC, 1=AC, 2=MA, 3=MB
//
// Parameters:
//   DEBOUNCE_W  debounce counter width; a level change is accepted after
//               2^DEBOUNCE_W consecutive differing synchronized samples
//   AUTO_W      auto-cycle timer width (DISPLAY_AUTOCYCLE_EN builds only)
//
// Build option:
//   DISPLAY_AUTOCYCLE_EN  when defined, an AUTO_W-bit timer steps the selection
//                         automatically each time it wraps, unless frozen.

module display_source #(
    parameter int DEBOUNCE_W = 16,
    parameter int AUTO_W     = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_raw,
    input  logic        freeze,
    input  logic [11:0] pc,
    input  logic [11:0] ac,
    input  logic [11:0] ma,
    input  logic [11:0] mb,
    output logic [11:0] value,
    output logic [3:0]  dots,
    output logic [1:0]  sel
);

    // Elaboration-time guard against degenerate counter widths.
    if (DEBOUNCE_W < 1 || AUTO_W < 1) begin : g_bad_width
        $error("display_source: DEBOUNCE_W and AUTO_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    logic                  s1;
    logic                  s2;
    logic                  stable;
    logic [DEBOUNCE_W-1:0] cnt;

    // Press event: the cycle in which the debounced level is about to
    // flip from released to pressed.
    logic press;
    always_comb begin
        press = s2 && !stable && (cnt == {DEBOUNCE_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            // Any sample agreeing with the accepted level restarts the count,
            // so a single-cycle bounce throws away all progress.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == {DEBOUNCE_W{1'b1}}) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional auto-cycle timer
    // ------------------------------------------------------------------
    logic auto_adv;

`ifdef DISPLAY_AUTOCYCLE_EN
    logic [AUTO_W-1:0] timer;

    // A real press in the same cycle takes priority; freeze parks the timer.
    always_comb begin
        auto_adv = !press && !freeze && (timer == {AUTO_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (press) begin
            timer <= '0;
        end else if (!freeze) begin
            // Natural wrap from all-ones to zero coincides with auto_adv.
            timer <= timer + 1'b1;
        end
    end
`else
    always_comb begin
        auto_adv = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Selection, decimal points and displayed value
    // ------------------------------------------------------------------
    logic        advance;
    logic [1:0]  sel_next;
    logic        sel_changed;
    logic [11:0] mux_word;

    always_comb begin
        advance  = press || auto_adv;
        sel_next = advance ? (sel + 2'd1) : sel;
    end

    always_comb begin
        mux_word = pc;
        case (sel)
            2'd0: mux_word = pc;
            2'd1: mux_word = ac;
            2'd2: mux_word = ma;
            2'd3: mux_word = mb;
            default: mux_word = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel         <= 2'd0;
            dots        <= 4'b0001;
            value       <= 12'o0000;
            sel_changed <= 1'b0;
        end else begin
            sel         <= sel_next;
            // Built from sel_next so dots and sel always update together.
            dots        <= 4'b0001 << sel_next;
            sel_changed <= advance;
            // While frozen, a fresh selection still takes one snapshot so the
            // newly chosen register is shown instead of the stale word.
            if (!freeze || sel_changed) begin
                value <= mux_word;
            end
        end
    end

endmodule

// File: tb/tb_display_source.sv
// tb/tb_display_source.sv - scoreboard testbench for display_source

module tb_display_source;

    logic        clk;
    logic        reset;
    logic        btn_raw;
    logic        freeze;
    logic [11:0] pc;
    logic [11:0] ac;
    logic [11:0] ma;
    logic [11:0] mb;
    logic [11:0] value;
    logic [3:0]  dots;
    logic [1:0]  sel;

    display_source #(
        .DEBOUNCE_W(4),
        .AUTO_W    (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .freeze (freeze),
        .pc     (pc),
        .ac     (ac),
        .ma     (ma),
        .mb     (mb),
        .value  (value),
        .dots   (dots),
        .sel    (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [17:0] exp;
        logic [17:0] mask;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [17:0] MASK_ALL = 18'h3FFFF;
    localparam logic [17:0] MASK_SD  = 18'h3F000;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got sel=%0d dots=%b value=%o, expected sel=%0d dots=%b value=%o",
                     tag, got[17:16], got[15:12], got[11:0], exp[17:16], exp[15:12], exp[11:0]);
        end
    endtask

    // Advance one clock edge and return on the following falling edge,
    // where outputs are sampled and new inputs are applied.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] d;
        d = 4'b0001 << s;
        return d;
    endfunction

    // Push the expectation for the next edge, clock it, then pop and compare.
    task automatic cyc(input string tag, input logic [1:0] s, input logic [11:0] v,
                       input logic [17:0] mask);
        exp_t e;
        exp_t got_e;
        e.tag  = tag;
        e.exp  = {s, onehot(s), v};
        e.mask = mask;
        sb.push_back(e);
        step();
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, expected an entry", tag);
        end else begin
            got_e = sb.pop_front();
            check(got_e.tag, {sel, dots, value} & got_e.mask, got_e.exp & got_e.mask);
        end
    endtask

    // Clean press from a released button: with DEBOUNCE_W=4 sel moves on the
    // 18th edge after btn_raw rises and value follows one edge later.
    task automatic press(input string tag, input logic [1:0] s_new,
                         input logic [11:0] v18, input logic [11:0] v19);
        btn_raw = 1'b1;
        wait_n(17);
        cyc({tag, "_e18"}, s_new, v18, MASK_ALL);
        cyc({tag, "_e19"}, s_new, v19, MASK_ALL);
        btn_raw = 1'b0;
        wait_n(19);
        cyc({tag, "_rel"}, s_new, v19, MASK_ALL);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b0;
        freeze  = 1'b0;
        pc      = 12'o1234;
        ac      = 12'o2345;
        ma      = 12'o3456;
        mb      = 12'o4567;

        // Reset state held for three edges.
        cyc("rst0", 2'd0, 12'o0000, MASK_ALL);
        cyc("rst1", 2'd0, 12'o0000, MASK_ALL);
        cyc("rst2", 2'd0, 12'o0000, MASK_ALL);
        reset = 1'b0;

`ifdef DISPLAY_AUTOCYCLE_EN
        // Auto-advance every 16 edges: edges 16 and 32 after reset release.
        wait_n(14);
        cyc("auto_e15", 2'd0, 12'o0, MASK_SD);
        cyc("auto_e16", 2'd1, 12'o0, MASK_SD);
        wait_n(7);
        // Press rising after edge 23 lands its event on edge 41 (timer=8).
        btn_raw = 1'b1;
        wait_n(8);
        cyc("auto_e32", 2'd2, 12'o0, MASK_SD);
        wait_n(8);
        cyc("auto_press", 2'd3, 12'o0, MASK_SD);
        btn_raw = 1'b0;
        wait_n(14);
        cyc("auto_e56", 2'd3, 12'o0, MASK_SD);
        cyc("auto_e57", 2'd0, 12'o0, MASK_SD);
        freeze = 1'b1;
        wait_n(19);
        cyc("auto_frz20", 2'd0, 12'o0, MASK_SD);
        wait_n(19);
        cyc("auto_frz40", 2'd0, 12'o0, MASK_SD);
`else
        // Pass-through.
        cyc("pass_1234", 2'd0, 12'o1234, MASK_ALL);
        pc = 12'o7777;
        cyc("pass_7777", 2'd0, 12'o7777, MASK_ALL);

        // Clean press: nothing before edge 18.
        btn_raw = 1'b1;
        wait_n(16);
        cyc("clean_e17", 2'd0, 12'o7777, MASK_ALL);
        cyc("clean_e18", 2'd1, 12'o7777, MASK_ALL);
        cyc("clean_e19", 2'd1, 12'o2345, MASK_ALL);
        btn_raw = 1'b0;
        wait_n(19);
        cyc("clean_rel", 2'd1, 12'o2345, MASK_ALL);

        // Bounce rejection.
        btn_raw = 1'b1;
        wait_n(10);
        btn_raw = 1'b0;
        wait_n(1);
        btn_raw = 1'b1;
        wait_n(9);
        cyc("bounce_hold", 2'd1, 12'o2345, MASK_ALL);
        wait_n(15);
        cyc("bounce_adv", 2'd2, 12'o3456, MASK_ALL);
        btn_raw = 1'b0;
        wait_n(20);
        cyc("bounce_rel", 2'd2, 12'o3456, MASK_ALL);

        // Wrap through all four selections from reset.
        reset = 1'b1;
        cyc("rst_again", 2'd0, 12'o0000, MASK_ALL);
        reset = 1'b0;
        press("wrap1", 2'd1, 12'o7777, 12'o2345);
        press("wrap2", 2'd2, 12'o2345, 12'o3456);
        press("wrap3", 2'd3, 12'o3456, 12'o4567);
        press("wrap0", 2'd0, 12'o4567, 12'o7777);

        // Freeze snapshot.
        pc = 12'o0100;
        wait_n(1);
        cyc("frz_pre", 2'd0, 12'o0100, MASK_ALL);
        freeze = 1'b1;
        pc = 12'o0200;
        wait_n(2);
        cyc("frz_hold", 2'd0, 12'o0100, MASK_ALL);
        press("frz_ac", 2'd1, 12'o0100, 12'o2345);
        ma = 12'o0555;
        press("frz_ma", 2'd2, 12'o2345, 12'o0555);
        ma = 12'o0111;
        wait_n(2);
        cyc("frz_ma_hold", 2'd2, 12'o0555, MASK_ALL);
        freeze = 1'b0;
        cyc("frz_resume", 2'd2, 12'o0111, MASK_ALL);
`endif

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
